// File: rtl/cache_refill_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared constants and types for the cache refill engine.
//   - Default geometry of the direct-mapped cache (block width, blocks per
//     line, number of lines, address width).
//   - Address field widths derived from that geometry, laid out as
//     {tag, index, block offset}.
//   - state_t : refill engine states.
// Optional feature macro used by the refill engine: CRITICAL_WORD_FIRST_EN.
// ---------------------------------------------------------------------------
package cache_pkg;

   localparam int CACHE_BLOCK_SIZE      = 32;
   localparam int CACHE_BLOCKS_PER_LINE = 4;
   localparam int CACHE_NUM_LINES       = 4;
   localparam int CACHE_ADDRESS_SIZE    = 32;

   localparam int BLOCK_OFFSET_LENGTH = $clog2(CACHE_BLOCKS_PER_LINE);
   localparam int INDEX_LENGTH        = $clog2(CACHE_NUM_LINES);
   localparam int TAG_LENGTH          = CACHE_ADDRESS_SIZE - INDEX_LENGTH - BLOCK_OFFSET_LENGTH;
   localparam int LINE_WIDTH          = CACHE_BLOCK_SIZE * CACHE_BLOCKS_PER_LINE;

   typedef enum logic [2:0] {
      IDLE,
      WB_CMD,
      WB_DATA,
      FILL_CMD,
      FILL_DATA,
      INSTALL,
      DONE
   } state_t;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl_if
// Memory-side bus of the refill engine: a command channel, a write-beat
// channel and a read-beat channel.
//   cmd_valid / cmd_ready / cmd_we / cmd_addr : burst command (we=1 writeback)
//   wvalid / wready / wdata                   : writeback beats
//   rvalid / rdata                            : fill beats, no backpressure
// Modports:
//   master : the refill engine
//   slave  : the backing memory
// ---------------------------------------------------------------------------
interface cache_refill_ctrl_if
   import cache_pkg::*;
#(
   parameter int ADDRESS_SIZE = CACHE_ADDRESS_SIZE,
   parameter int BLOCK_SIZE   = CACHE_BLOCK_SIZE
);

   logic                    cmd_valid;
   logic                    cmd_ready;
   logic                    cmd_we;
   logic [ADDRESS_SIZE-1:0] cmd_addr;
   logic                    wvalid;
   logic                    wready;
   logic [BLOCK_SIZE-1:0]   wdata;
   logic                    rvalid;
   logic [BLOCK_SIZE-1:0]   rdata;

   modport master (
      output cmd_valid, cmd_we, cmd_addr, wvalid, wdata,
      input  cmd_ready, wready, rvalid, rdata
   );

   modport slave (
      input  cmd_valid, cmd_we, cmd_addr, wvalid, wdata,
      output cmd_ready, wready, rvalid, rdata
   );

endinterface

// File: rtl/cache_refill_ctrl_line_assembler.sv
// ---------------------------------------------------------------------------
// cache_line_assembler
// Beat counter shared by the writeback and fill bursts, plus the line
// register that collects fill beats.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   clear         : restart the beat counter at 0
//   advance       : one beat accepted, bump the counter (wraps after last)
//   load          : write data into line slot (start_offset + beat) mod NUM
//   start_offset  : first slot of the burst (0 for line-aligned fills)
//   data          : beat data
//   beat          : current beat number
//   last          : current beat is the final one of the burst
//   line          : assembled line, block k at [k*BLOCK_SIZE +: BLOCK_SIZE]
// ---------------------------------------------------------------------------
module cache_line_assembler
   import cache_pkg::*;
#(
   parameter int BLOCK_SIZE             = CACHE_BLOCK_SIZE,
   parameter int NUM_OF_BLOCKS_PER_LINE = CACHE_BLOCKS_PER_LINE
)(
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       clear,
   input  logic                                       advance,
   input  logic                                       load,
   input  logic [$clog2(NUM_OF_BLOCKS_PER_LINE)-1:0]  start_offset,
   input  logic [BLOCK_SIZE-1:0]                      data,
   output logic [$clog2(NUM_OF_BLOCKS_PER_LINE)-1:0]  beat,
   output logic                                       last,
   output logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] line
);

   localparam int OFF_W = $clog2(NUM_OF_BLOCKS_PER_LINE);

   logic [OFF_W-1:0] slot;

   // The counter is exactly OFF_W bits wide, so both the slot sum and the
   // post-last-beat increment wrap modulo the line length for free.
   assign slot = start_offset + beat;
   assign last = (beat == OFF_W'(NUM_OF_BLOCKS_PER_LINE - 1));

   // Beat counter and slot-indexed line register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat <= '0;
         line <= '0;
      end else begin
         if (clear) begin
            beat <= '0;
         end else if (advance) begin
            beat <= beat + 1'b1;
         end
         if (load) begin
            line[slot*BLOCK_SIZE +: BLOCK_SIZE] <= data;
         end
      end
   end

endmodule

// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
// Memory-side refill engine of the direct-mapped cache. On a miss it writes
// back the dirty victim line (if any), fetches the missing line one block per
// beat, installs the assembled line into the cache and pulses done.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   miss_i           : one-cycle miss request, accepted in IDLE or DONE
//   miss_addr_i      : missing block address {tag, index, offset}
//   victim_dirty_i   : victim line must be written back first
//   victim_tag_i     : victim tag
//   victim_line_i    : victim data, sampled together with miss_i
//   busy_o           : refill in progress
//   done_o           : one-cycle pulse after the line is installed
//   write_line_o     : one-cycle install strobe to the cache
//   address_o        : line-aligned install address
//   line_o           : assembled line
//   fwd_valid_o/fwd_data_o : first fill beat forwarded (feature build only)
//   mem              : memory bus (master side)
// Optional feature: `define CRITICAL_WORD_FIRST_EN to start the fill at the
// missing block and forward it as soon as it arrives.
// ---------------------------------------------------------------------------
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int BLOCK_SIZE             = CACHE_BLOCK_SIZE,
   parameter int NUM_OF_BLOCKS_PER_LINE = CACHE_BLOCKS_PER_LINE,
   parameter int NUM_OF_CACHE_LINES     = CACHE_NUM_LINES,
   parameter int ADDRESS_SIZE           = CACHE_ADDRESS_SIZE
)(
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         miss_i,
   input  logic [ADDRESS_SIZE-1:0]                      miss_addr_i,
   input  logic                                         victim_dirty_i,
   input  logic [ADDRESS_SIZE-$clog2(NUM_OF_CACHE_LINES)-$clog2(NUM_OF_BLOCKS_PER_LINE)-1:0] victim_tag_i,
   input  logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] victim_line_i,
   output logic                                         busy_o,
   output logic                                         done_o,
   output logic                                         write_line_o,
   output logic [ADDRESS_SIZE-1:0]                      address_o,
   output logic [NUM_OF_BLOCKS_PER_LINE*BLOCK_SIZE-1:0] line_o,
`ifdef CRITICAL_WORD_FIRST_EN
   output logic                                         fwd_valid_o,
   output logic [BLOCK_SIZE-1:0]                        fwd_data_o,
`endif
   cache_refill_ctrl_if.master                          mem
);

   localparam int OFF_W  = $clog2(NUM_OF_BLOCKS_PER_LINE);
   localparam int IDX_W  = $clog2(NUM_OF_CACHE_LINES);
   localparam int TAG_W  = ADDRESS_SIZE - IDX_W - OFF_W;
   localparam int LINE_W = NUM_OF_BLOCKS_PER_LINE * BLOCK_SIZE;

   state_t                     state_q;
   state_t                     state_d;
   logic [ADDRESS_SIZE-OFF_W-1:0] miss_line_q;
   logic [TAG_W-1:0]           victim_tag_q;
   logic [LINE_W-1:0]          victim_line_q;
   logic                       accept;

   logic                       beat_clear;
   logic                       beat_advance;
   logic                       slot_load;
   logic [OFF_W-1:0]           beat;
   logic                       last_beat;
   logic [OFF_W-1:0]           start_offset;
   logic [ADDRESS_SIZE-1:0]    fill_addr;

`ifdef CRITICAL_WORD_FIRST_EN
   logic [OFF_W-1:0]           miss_off_q;

   // The fill burst begins at the missing block; its first beat goes
   // straight to the CPU side without waiting for the install.
   assign start_offset = miss_off_q;
   assign fill_addr    = {miss_line_q, miss_off_q};
   assign fwd_valid_o  = (state_q == FILL_DATA) && mem.rvalid && (beat == '0);
   assign fwd_data_o   = fwd_valid_o ? mem.rdata : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         miss_off_q <= '0;
      end else if (accept) begin
         miss_off_q <= miss_addr_i[OFF_W-1:0];
      end
   end
`else
   assign start_offset = '0;
   assign fill_addr    = {miss_line_q, {OFF_W{1'b0}}};
`endif

   assign address_o = {miss_line_q, {OFF_W{1'b0}}};

   cache_line_assembler #(
      .BLOCK_SIZE             (BLOCK_SIZE),
      .NUM_OF_BLOCKS_PER_LINE (NUM_OF_BLOCKS_PER_LINE)
   ) u_assembler (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (beat_clear),
      .advance      (beat_advance),
      .load         (slot_load),
      .start_offset (start_offset),
      .data         (mem.rdata),
      .beat         (beat),
      .last         (last_beat),
      .line         (line_o)
   );

   // State register and the miss context captured on accept. The context
   // stays put for the whole refill, so later miss_i pulses cannot disturb
   // the addresses or the writeback data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         miss_line_q   <= '0;
         victim_tag_q  <= '0;
         victim_line_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            miss_line_q   <= miss_addr_i[ADDRESS_SIZE-1:OFF_W];
            victim_tag_q  <= victim_tag_i;
            victim_line_q <= victim_line_i;
         end
      end
   end

   // Next-state and output decode. DONE behaves like IDLE for new misses so
   // a request arriving in the same cycle as done_o is not lost.
   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      busy_o       = 1'b1;
      done_o       = 1'b0;
      write_line_o = 1'b0;
      mem.cmd_valid = 1'b0;
      mem.cmd_we    = 1'b0;
      mem.cmd_addr  = '0;
      mem.wvalid    = 1'b0;
      mem.wdata     = '0;
      beat_clear   = 1'b0;
      beat_advance = 1'b0;
      slot_load    = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            busy_o = 1'b0;
            done_o = (state_q == DONE);
            accept = miss_i;
            if (miss_i) begin
               state_d = victim_dirty_i ? WB_CMD : FILL_CMD;
            end else begin
               state_d = IDLE;
            end
         end
         WB_CMD: begin
            mem.cmd_valid = 1'b1;
            mem.cmd_we    = 1'b1;
            mem.cmd_addr  = {victim_tag_q, miss_line_q[IDX_W-1:0], {OFF_W{1'b0}}};
            if (mem.cmd_ready) begin
               beat_clear = 1'b1;
               state_d    = WB_DATA;
            end
         end
         WB_DATA: begin
            mem.wvalid = 1'b1;
            mem.wdata  = victim_line_q[beat*BLOCK_SIZE +: BLOCK_SIZE];
            if (mem.wready) begin
               beat_advance = 1'b1;
               if (last_beat) begin
                  state_d = FILL_CMD;
               end
            end
         end
         FILL_CMD: begin
            mem.cmd_valid = 1'b1;
            mem.cmd_addr  = fill_addr;
            if (mem.cmd_ready) begin
               beat_clear = 1'b1;
               state_d    = FILL_DATA;
            end
         end
         FILL_DATA: begin
            if (mem.rvalid) begin
               beat_advance = 1'b1;
               slot_load    = 1'b1;
               if (last_beat) begin
                  state_d = INSTALL;
               end
            end
         end
         INSTALL: begin
            write_line_o = 1'b1;
            state_d      = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
